// File: rtl/fp_accumulator.sv
// Sequential FP32 accumulator: folds a stream of operands into a running sum through
// one external adder, one operation in flight, and emits each completed sum downstream.
module fp_accumulator #(
    parameter int          MAX_TERMS = 256,
    parameter logic [31:0] BIAS_INIT = 32'h0000_0000,
    parameter int          CNT_W     = $clog2(MAX_TERMS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    input  logic             in_STB,
    output logic             in_BUSY,
    output logic [31:0]      adder_input_a,
    output logic [31:0]      adder_input_b,
    output logic             adder_input_STB,
    input  logic             adder_BUSY,
    input  logic [31:0]      adder_sum,
    input  logic             adder_output_STB,
    output logic             adder_out_BUSY,
    output logic [31:0]      acc_sum,
    output logic [CNT_W-1:0] acc_count,
    output logic             acc_trunc,
    output logic             acc_STB,
    input  logic             out_BUSY
);

    typedef enum logic [2:0] {S_IDLE, S_GET, S_ISSUE, S_WAIT, S_OUT} state_t;

    state_t             state_q, state_d;
    logic [31:0]        acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic               last_q, last_d;
    logic               in_busy_q, in_busy_d;
    logic [31:0]        a_q, a_d, b_q, b_d;
    logic               astb_q, astb_d;
    logic               aobusy_q, aobusy_d;
    logic [31:0]        sum_q, sum_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               trunc_q, trunc_d;
    logic               ostb_q, ostb_d;

    // cnt is at most MAX_TERMS-1 while waiting, so the increment cannot overflow CNT_W
    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        in_busy_d = in_busy_q;
        a_d       = a_q;
        b_d       = b_q;
        astb_d    = astb_q;
        aobusy_d  = aobusy_q;
        sum_d     = sum_q;
        count_d   = count_q;
        trunc_d   = trunc_q;
        ostb_d    = ostb_q;
        case (state_q)
            S_IDLE: begin
                acc_d     = BIAS_INIT;
                cnt_d     = '0;
                in_busy_d = 1'b0;
                state_d   = S_GET;
            end
            S_GET: begin
                if (in_STB && !in_busy_q) begin
                    last_d    = in_last;
                    in_busy_d = 1'b1;
                    a_d       = acc_q;
                    b_d       = in_data;
                    astb_d    = 1'b1;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!adder_BUSY) begin
                    astb_d  = 1'b0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (adder_output_STB) begin
                    acc_d = adder_sum;
                    cnt_d = cnt_inc;
                    if (last_q || cnt_inc == CNT_W'(MAX_TERMS)) begin
                        sum_d    = adder_sum;
                        count_d  = cnt_inc;
                        trunc_d  = !last_q;
                        ostb_d   = 1'b1;
                        aobusy_d = 1'b1;
                        state_d  = S_OUT;
                    end else begin
                        in_busy_d = 1'b0;
                        state_d   = S_GET;
                    end
                end
            end
            S_OUT: begin
                if (!out_BUSY) begin
                    ostb_d    = 1'b0;
                    aobusy_d  = 1'b0;
                    acc_d     = BIAS_INIT;
                    cnt_d     = '0;
                    in_busy_d = 1'b0;
                    state_d   = S_GET;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            last_q    <= 1'b0;
            in_busy_q <= 1'b1;
            a_q       <= '0;
            b_q       <= '0;
            astb_q    <= 1'b0;
            aobusy_q  <= 1'b0;
            sum_q     <= '0;
            count_q   <= '0;
            trunc_q   <= 1'b0;
            ostb_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            in_busy_q <= in_busy_d;
            a_q       <= a_d;
            b_q       <= b_d;
            astb_q    <= astb_d;
            aobusy_q  <= aobusy_d;
            sum_q     <= sum_d;
            count_q   <= count_d;
            trunc_q   <= trunc_d;
            ostb_q    <= ostb_d;
        end
    end

    assign in_BUSY         = in_busy_q;
    assign adder_input_a   = a_q;
    assign adder_input_b   = b_q;
    assign adder_input_STB = astb_q;
    assign adder_out_BUSY  = aobusy_q;
    assign acc_sum         = sum_q;
    assign acc_count       = count_q;
    assign acc_trunc       = trunc_q;
    assign acc_STB         = ostb_q;

endmodule
